// File: rtl/hc4e_pkg.sv
// Shared HC4e definitions: ALU op codes, execute-FSM encoding, datapath widths and
// the registered ALU drive bundle.
package hc4e_pkg;

  localparam int REG_W     = 4;
  localparam int REG_IDX_W = 4;

  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_THRU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Everything the sibling ALU sees; held as one register so all four outputs move together.
  typedef struct packed {
    logic [2:0]       sel;
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
    logic             cin;
  } alu_drv_t;

  localparam alu_drv_t ALU_DRV_RST = '{sel: OP_THRU, a: '0, b: '0, cin: 1'b0};

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_XOR) || (op == OP_THRU);
  endfunction

endpackage

// File: rtl/hc4e_regfile.sv
// HC4e register file: NREG x REG_W, two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear of every entry to RST_R.
module hc4e_regfile
  import hc4e_pkg::*;
#(
  parameter int               NREG  = 16,
  parameter logic [REG_W-1:0] RST_R = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [REG_W-1:0]     i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  output logic [REG_W-1:0]     o_rdata_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  output logic [REG_W-1:0]     o_rdata_b
);

  logic [REG_W-1:0] r_mem [NREG];

  // NOTE: this array is reset on purpose -- architectural state must read RST_R after
  // reset, so it is built from flops; storage without that need should stay unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= RST_R;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_exec_ctrl.sv
// HC4e execute-stage sequencer: accepts one op per handshake, drives the sibling ALU
// from registers, writes result and carry back. Optional macro: ALU_ZERO_FLAG_EN.
module alu_exec_ctrl
  import hc4e_pkg::*;
#(
  parameter int               NREG  = 16,
  parameter logic [REG_W-1:0] RST_R = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [REG_IDX_W-1:0] req_rd,
  input  logic [REG_IDX_W-1:0] req_rs,
  input  logic                 req_use_carry,
  output logic [REG_W-1:0]     alu_a,
  output logic [REG_W-1:0]     alu_b,
  output logic [2:0]           alu_sel,
  output logic                 alu_cin,
  input  logic [REG_W-1:0]     alu_out,
  input  logic                 alu_cout,
  output logic                 done,
  output logic                 err,
  output logic                 carry_flag,
  output logic [REG_W-1:0]     dbg_rs_data
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                 zero_flag
`endif
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_illegal;
  logic                   w_wb;
  logic [REG_IDX_W-1:0]   r_rd;
  alu_drv_t               r_drv;
  alu_drv_t               w_drv_nxt;
  logic [REG_W-1:0]       w_rd_data;
  logic [REG_W-1:0]       w_rs_data;
  logic                   r_carry;
  logic                   r_done;
  logic                   r_err;

  hc4e_regfile #(
    .NREG  (NREG),
    .RST_R (RST_R)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_wb),
    .i_waddr   (r_rd),
    .i_wdata   (alu_out),
    .i_raddr_a (req_rd),
    .o_rdata_a (w_rd_data),
    .i_raddr_b (req_rs),
    .o_rdata_b (w_rs_data)
  );

  // NOTE: next state and strobes get defaults before the case so every path assigns
  // them; a missing assignment here would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_illegal   = 1'b0;
    w_wb        = 1'b0;
    req_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_legal_op(req_op)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_EXEC;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB: begin
        w_wb        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands are captured at accept. XOR folds R[rs] into A so the ALU sees B=0 on
  // XOR just as on THRU; the ALU's XOR of A with zero then yields R[rd]^R[rs].
  always_comb begin
    w_drv_nxt.sel = req_op;
    w_drv_nxt.a   = w_rd_data;
    w_drv_nxt.b   = w_rs_data;
    w_drv_nxt.cin = req_use_carry & r_carry;
    if (req_op == OP_THRU) begin
      w_drv_nxt.a = w_rs_data;
      w_drv_nxt.b = '0;
    end else if (req_op == OP_XOR) begin
      w_drv_nxt.a = w_rd_data ^ w_rs_data;
      w_drv_nxt.b = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ALU drive only changes on accept, so it holds steady through EXEC, WB and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drv <= ALU_DRV_RST;
      r_rd  <= '0;
    end else if (w_accept) begin
      r_drv <= w_drv_nxt;
      r_rd  <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_wb;
      r_err  <= w_illegal;
      if (w_wb) r_carry <= alu_cout;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_zero <= 1'b0;
    else if (w_wb) r_zero <= (alu_out == '0);
  end

  assign zero_flag = r_zero;
`endif

  assign alu_a       = r_drv.a;
  assign alu_b       = r_drv.b;
  assign alu_sel     = r_drv.sel;
  assign alu_cin     = r_drv.cin;
  assign done        = r_done;
  assign err         = r_err;
  assign carry_flag  = r_carry;
  assign dbg_rs_data = w_rs_data;

endmodule
